// File: rtl/plat_land_scan.sv
// ---------------------------------------------------------------------------
// plat_land_scan
// Sequential landing scanner: on scan_start it latches the player position and
// walks the per-block platform descriptors one entry per cycle, reporting the
// highest platform top surface the feet crossed during the last physics step.
// Optional head-bump detection is built when PLAT_CEIL_HIT_EN is defined;
// otherwise ceil_hit / ceil_y are tied to zero.
// ---------------------------------------------------------------------------
module plat_land_scan #(
   parameter int PLATFORM_NUM_PER_BLOCK = 7,
   parameter int PHY_WIDTH              = 16,
   parameter int BLOCK_LEN_WIDTH        = 4,
   parameter int UNIT_W                 = 8,
   parameter int PLAT_H                 = 8,
   parameter int CHAR_W                 = 16,
   parameter int IDX_WIDTH              = 3
) (
   input  logic                                          sys_clk,
   input  logic                                          sys_rst,
   input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_x,
   input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_y,
   input  logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len,
   input  logic                                          block_switch,
   input  logic                                          scan_start,
   input  logic [PHY_WIDTH-1:0]                          player_x,
   input  logic [PHY_WIDTH-1:0]                          foot_y,
   input  logic [PHY_WIDTH-1:0]                          prev_foot_y,
   output logic                                          busy,
   output logic                                          scan_done,
   output logic                                          land_hit,
   output logic [IDX_WIDTH-1:0]                          land_idx,
   output logic [PHY_WIDTH-1:0]                          land_y,
   output logic                                          ceil_hit,
   output logic [PHY_WIDTH-1:0]                          ceil_y
);

   // One extra bit so right edges and top surfaces never wrap.
   localparam int PW1 = PHY_WIDTH + 1;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(PLATFORM_NUM_PER_BLOCK - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_start;
   logic                  w_restart;
   logic                  w_last;

   logic [IDX_WIDTH-1:0]  r_idx;
   logic [PHY_WIDTH-1:0]  r_px;
   logic [PHY_WIDTH-1:0]  r_foot;
   logic [PHY_WIDTH-1:0]  r_prev;

   logic                  r_best_hit;
   logic [PW1-1:0]        r_best_top;
   logic [IDX_WIDTH-1:0]  r_best_idx;

   logic [IDX_WIDTH-1:0]  w_eval_idx;
   logic [PHY_WIDTH-1:0]  w_x;
   logic [PHY_WIDTH-1:0]  w_y;
   logic [BLOCK_LEN_WIDTH-1:0] w_len;

   logic [PW1-1:0]        w_len_px;
   logic [PW1-1:0]        w_x_ext;
   logic [PW1-1:0]        w_y_ext;
   logic [PW1-1:0]        w_right;
   logic [PW1-1:0]        w_top;
   logic [PW1-1:0]        w_pl_left;
   logic [PW1-1:0]        w_pl_right;
   logic                  w_overlap;
   logic                  w_land;

   logic                  w_base_hit;
   logic                  w_take;
   logic                  w_nbest_hit;
   logic [PW1-1:0]        w_nbest_top;
   logic [IDX_WIDTH-1:0]  w_nbest_idx;

   // FSM next-state: start/accept, restart on block switch, finish after last entry.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_restart   = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (scan_start) begin
               w_state_nxt = S_SCAN;
               w_start     = 1'b1;
            end
         end
         S_SCAN: begin
            if (block_switch) begin
               w_restart = 1'b1;
            end else if (r_idx == LAST_IDX) begin
               w_last      = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (scan_start) begin
               w_state_nxt = S_SCAN;
               w_start     = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   assign busy      = (r_state == S_SCAN);
   assign scan_done = (r_state == S_DONE);

   // Descriptor select; a restart cycle already evaluates entry 0 of the new block.
   always_comb begin
      w_eval_idx = w_restart ? '0 : r_idx;
      w_x        = '0;
      w_y        = '0;
      w_len      = '0;
      for (int i = 0; i < PLATFORM_NUM_PER_BLOCK; i++) begin
         if (w_eval_idx == IDX_WIDTH'(i)) begin
            w_x   = plat_relative_x[i*PHY_WIDTH +: PHY_WIDTH];
            w_y   = plat_relative_y[i*PHY_WIDTH +: PHY_WIDTH];
            w_len = plat_len[i*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
         end
      end
   end

   // Landing test for the selected entry and merge into the running best.
   always_comb begin
      w_len_px    = PW1'(w_len) * PW1'(UNIT_W);
      w_x_ext     = {1'b0, w_x};
      w_y_ext     = {1'b0, w_y};
      w_right     = w_x_ext + w_len_px;
      w_top       = w_y_ext + PW1'(PLAT_H);
      w_pl_left   = {1'b0, r_px};
      w_pl_right  = w_pl_left + PW1'(CHAR_W);
      // Zero-length platforms have no extent; strict compares exclude touching edges.
      w_overlap   = (w_len != '0) && (w_pl_right > w_x_ext) && (w_pl_left < w_right);
      w_land      = w_overlap && ({1'b0, r_prev} >= w_top) && ({1'b0, r_foot} <= w_top);
      w_base_hit  = w_restart ? 1'b0 : r_best_hit;
      // Strictly greater keeps the earlier (lower) index on equal tops.
      w_take      = w_land && (!w_base_hit || (w_top > r_best_top));
      w_nbest_hit = w_base_hit | w_land;
      w_nbest_top = w_take ? w_top : r_best_top;
      w_nbest_idx = w_take ? w_eval_idx : r_best_idx;
   end

   // Scan datapath: latch player on accept, advance index and best while scanning.
   always_ff @(posedge sys_clk) begin
      if (w_start) begin
         r_px       <= player_x;
         r_foot     <= foot_y;
         r_prev     <= prev_foot_y;
         r_idx      <= '0;
         r_best_hit <= 1'b0;
      end else if (r_state == S_SCAN) begin
         r_idx      <= w_eval_idx + 1'b1;
         r_best_hit <= w_nbest_hit;
         r_best_top <= w_nbest_top;
         r_best_idx <= w_nbest_idx;
      end
   end

   // Landing result registers: hold from one completed scan to the next.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         land_hit <= 1'b0;
         land_idx <= '0;
         land_y   <= '0;
      end else if (w_last) begin
         land_hit <= w_nbest_hit;
         land_idx <= w_nbest_hit ? w_nbest_idx : '0;
         land_y   <= w_nbest_hit ? w_nbest_top[PHY_WIDTH-1:0] : '0;
      end
   end

`ifdef PLAT_CEIL_HIT_EN
   logic                  r_best_chit;
   logic [PHY_WIDTH-1:0]  r_best_cy;
   logic [PW1-1:0]        w_hprev;
   logic [PW1-1:0]        w_hcur;
   logic                  w_bump;
   logic                  w_cbase_hit;
   logic                  w_ctake;
   logic                  w_nbest_chit;
   logic [PHY_WIDTH-1:0]  w_nbest_cy;

   // Head-bump test: the head rose through the platform underside; lowest underside wins.
   always_comb begin
      w_hprev      = {1'b0, r_prev} + PW1'(CHAR_W);
      w_hcur       = {1'b0, r_foot} + PW1'(CHAR_W);
      w_bump       = w_overlap && (w_hprev <= w_y_ext) && (w_hcur >= w_y_ext);
      w_cbase_hit  = w_restart ? 1'b0 : r_best_chit;
      w_ctake      = w_bump && (!w_cbase_hit || (w_y < r_best_cy));
      w_nbest_chit = w_cbase_hit | w_bump;
      w_nbest_cy   = w_ctake ? w_y : r_best_cy;
   end

   // Ceiling running best, cleared on accept and advanced while scanning.
   always_ff @(posedge sys_clk) begin
      if (w_start) begin
         r_best_chit <= 1'b0;
      end else if (r_state == S_SCAN) begin
         r_best_chit <= w_nbest_chit;
         r_best_cy   <= w_nbest_cy;
      end
   end

   // Ceiling result registers, updated together with the landing result.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         ceil_hit <= 1'b0;
         ceil_y   <= '0;
      end else if (w_last) begin
         ceil_hit <= w_nbest_chit;
         ceil_y   <= w_nbest_chit ? w_nbest_cy : '0;
      end
   end
`else
   assign ceil_hit = 1'b0;
   assign ceil_y   = '0;
`endif

endmodule

// File: tb/tb_plat_land_scan.sv
// ---------------------------------------------------------------------------
// tb_plat_land_scan
// Scoreboard bench: expected results are computed from the descriptor arrays
// when a scan is launched and compared when scan_done appears.
// ---------------------------------------------------------------------------
module tb_plat_land_scan;

   localparam int N  = 7;
   localparam int PW = 16;
   localparam int LW = 4;

   logic            clk = 1'b0;
   logic            sys_rst;
   logic [N*PW-1:0] px_bus, py_bus;
   logic [N*LW-1:0] pl_bus;
   logic            block_switch, scan_start;
   logic [PW-1:0]   player_x, foot_y, prev_foot_y;
   logic            busy, scan_done, land_hit, ceil_hit;
   logic [2:0]      land_idx;
   logic [PW-1:0]   land_y, ceil_y;

   logic [PW-1:0]   ax [N];
   logic [PW-1:0]   ay [N];
   logic [LW-1:0]   al [N];

   typedef struct {
      logic        hit;
      logic [2:0]  idx;
      logic [15:0] y;
      logic        chit;
      logic [15:0] cy;
      int          due;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         px_bus[i*PW +: PW] = ax[i];
         py_bus[i*PW +: PW] = ay[i];
         pl_bus[i*LW +: LW] = al[i];
      end
   end

   plat_land_scan dut (
      .sys_clk         (clk),
      .sys_rst         (sys_rst),
      .plat_relative_x (px_bus),
      .plat_relative_y (py_bus),
      .plat_len        (pl_bus),
      .block_switch    (block_switch),
      .scan_start      (scan_start),
      .player_x        (player_x),
      .foot_y          (foot_y),
      .prev_foot_y     (prev_foot_y),
      .busy            (busy),
      .scan_done       (scan_done),
      .land_hit        (land_hit),
      .land_idx        (land_idx),
      .land_y          (land_y),
      .ceil_hit        (ceil_hit),
      .ceil_y          (ceil_y)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference behaviour from the platform geometry, using the present player inputs.
   function automatic exp_t model(input int due);
      exp_t r;
      int   x, len, right, top, pxi, fy, py, bt, by, hp, hc;
      bit   ov;
      r.hit = 0; r.idx = 0; r.y = 0; r.chit = 0; r.cy = 0; r.due = due;
      bt = 0; by = 0;
      pxi = int'(player_x); fy = int'(foot_y); py = int'(prev_foot_y);
      for (int i = 0; i < N; i++) begin
         x     = int'(ax[i]);
         len   = int'(al[i]);
         right = x + len * 8;
         top   = int'(ay[i]) + 8;
         ov    = (len != 0) && (pxi + 16 > x) && (pxi < right);
         if (ov && py >= top && fy <= top && (!r.hit || top > bt)) begin
            r.hit = 1; bt = top; r.idx = 3'(i); r.y = 16'(top);
         end
`ifdef PLAT_CEIL_HIT_EN
         hp = py + 16;
         hc = fy + 16;
         if (ov && hp <= int'(ay[i]) && hc >= int'(ay[i]) && (!r.chit || int'(ay[i]) < by)) begin
            r.chit = 1; by = int'(ay[i]); r.cy = ay[i];
         end
`else
         hp = 0; hc = 0;
`endif
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (scan_done) begin
         check("busy_with_done", busy, 0);
         if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = q.pop_front();
            check("done_cycle", cyc, e.due);
            check("land_hit", land_hit, e.hit);
            check("land_idx", land_idx, e.idx);
            check("land_y", land_y, e.y);
            check("ceil_hit", ceil_hit, e.chit);
            check("ceil_y", ceil_y, e.cy);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch();
      scan_start = 1'b1;
      q.push_back(model(cyc + N + 1));
      tick();
      scan_start = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 60 && q.size() != 0; k++) tick();
      if (q.size() != 0) begin
         check("drain_timeout", q.size(), 0);
         q.delete();
      end
      tick();
   endtask

   task automatic clear_plats();
      for (int i = 0; i < N; i++) begin
         ax[i] = '0; ay[i] = '0; al[i] = '0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sys_rst = 1'b1; block_switch = 1'b0; scan_start = 1'b0;
      player_x = '0; foot_y = '0; prev_foot_y = '0;
      clear_plats();
      repeat (3) tick();
      sys_rst = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", scan_done, 0);
      check("rst_land_hit", land_hit, 0);
      check("rst_land_idx", land_idx, 0);
      check("rst_land_y", land_y, 0);
      check("rst_ceil_hit", ceil_hit, 0);
      check("rst_ceil_y", ceil_y, 0);
      tick();

      // Basic landing; player inputs scrambled after accept must not matter.
      ax[0] = 16'd280; ay[0] = 16'd75; al[0] = 4'd10;
      player_x = 16'd300; prev_foot_y = 16'd90; foot_y = 16'd80;
      launch();
      player_x = 16'd0; prev_foot_y = 16'd0; foot_y = 16'd500;
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         check("busy_on", busy, 1);
         tick();
      end
      drain();
      check("basic_land_y_hold", land_y, 83);

      // Edge exclusion and the far edge just inside.
      player_x = 16'd264; prev_foot_y = 16'd90; foot_y = 16'd80;
      launch(); drain();
      check("edge_left_miss", land_hit, 0);
      player_x = 16'd359;
      launch(); drain();
      check("edge_right_hit", land_hit, 1);

      // Highest surface wins, then equal tops resolve to the lower index.
      clear_plats();
      ax[3] = 16'd200; ay[3] = 16'd112; al[3] = 4'd5;
      ax[5] = 16'd190; ay[5] = 16'd92;  al[5] = 4'd8;
      player_x = 16'd210; prev_foot_y = 16'd130; foot_y = 16'd90;
      launch(); drain();
      check("highest_idx", land_idx, 3);
      check("highest_y", land_y, 120);
      ax[2] = 16'd205; ay[2] = 16'd112; al[2] = 4'd3;
      launch(); drain();
      check("tie_idx", land_idx, 2);

      // Restart on block switch in the 4th busy cycle with new descriptors.
      begin
         int c;
         c = cyc;
         scan_start = 1'b1;
         tick();
         scan_start = 1'b0;
         tick(); tick(); tick();
         clear_plats();
         ax[6] = 16'd200; ay[6] = 16'd100; al[6] = 4'd4;
         block_switch = 1'b1;
         q.push_back(model(c + N + 1 + 3));
         tick();
         block_switch = 1'b0;
         drain();
         check("restart_idx", land_idx, 6);
      end

      // scan_start held high: accepted in each done cycle, new player values each time.
      begin
         int c;
         c = cyc;
         scan_start = 1'b1;
         player_x = 16'd210;
         q.push_back(model(c + 8));
         repeat (8) tick();
         player_x = 16'd100;
         q.push_back(model(c + 16));
         repeat (8) tick();
         player_x = 16'd210;
         q.push_back(model(c + 24));
         tick();
         scan_start = 1'b0;
         drain();
      end

      // Reset in the 3rd busy cycle: no completion, outputs back to zero.
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      tick(); tick();
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_land_hit", land_hit, 0);
      check("abort_land_idx", land_idx, 0);
      check("abort_land_y", land_y, 0);
      repeat (12) tick();

      // Ceiling bump from below.
      clear_plats();
      ax[1] = 16'd200; ay[1] = 16'd200; al[1] = 4'd4;
      player_x = 16'd205; prev_foot_y = 16'd170; foot_y = 16'd190;
      launch(); drain();
`ifdef PLAT_CEIL_HIT_EN
      check("ceil_direct_hit", ceil_hit, 1);
      check("ceil_direct_y", ceil_y, 200);
`else
      check("ceil_direct_hit", ceil_hit, 0);
      check("ceil_direct_y", ceil_y, 0);
`endif
      check("ceil_no_land", land_hit, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/plat_land_scan.md
# plat_land_scan

Sequential collision scanner that consumes the packed per-block platform descriptors (`plat_relative_x`, `plat_relative_y`, `plat_len`) and resolves player landing against them. On each `scan_start` it snapshots the player's block-relative position and walks the platform list one entry per cycle. It reports the highest platform whose top surface the player's feet crossed during the last physics step. It sits between the block generator and the physics update, which applies the snap-to-surface.

## Interface
- `PLATFORM_NUM_PER_BLOCK`, 7: descriptors per block.
- `PHY_WIDTH`, 16: coordinate width, unsigned, block-relative.
- `BLOCK_LEN_WIDTH`, 4: platform length field width, in units.
- `UNIT_W`, 8: pixels per length unit.
- `PLAT_H`, 8: platform thickness in pixels.
- `CHAR_W`, 16: player hitbox width in pixels.
- `IDX_WIDTH`, 3: index width, must satisfy 2^IDX_WIDTH ≥ PLATFORM_NUM_PER_BLOCK.

Ports:
- `sys_clk` in 1: system clock.
- `sys_rst` in 1: reset. One clock; reset is synchronous and active-high.
- `plat_relative_x` in N·PHY_WIDTH: packed platform left x; entry i at bits [i·PHY_WIDTH +: PHY_WIDTH].
- `plat_relative_y` in N·PHY_WIDTH: packed platform bottom y.
- `plat_len` in N·BLOCK_LEN_WIDTH: packed platform length in units.
- `block_switch` in 1: descriptors changed this cycle.
- `scan_start` in 1: request pulse.
- `player_x` in PHY_WIDTH: hitbox left x.
- `foot_y` in PHY_WIDTH: hitbox bottom y, current step.
- `prev_foot_y` in PHY_WIDTH: hitbox bottom y, previous step.
- `busy` out 1: scan in progress.
- `scan_done` out 1: one-cycle completion pulse.
- `land_hit` out 1: landing found.
- `land_idx` out IDX_WIDTH: index of the landed platform.
- `land_y` out PHY_WIDTH: top surface y of the landed platform.
- `ceil_hit` out 1: head bump found (feature-gated).
- `ceil_y` out PHY_WIDTH: bottom y of the bumped platform (feature-gated).

## Operation
- Axis convention: y increases upward. Platform i spans x in [x_i, x_i + len_i·UNIT_W) and y in [y_i, y_i + PLAT_H). Its top surface is T_i = y_i + PLAT_H.
- All sums are computed at PHY_WIDTH+1 bits. There is no wrap, so the right edge and T_i never overflow.
- Horizontal overlap: player_x + CHAR_W > x_i AND player_x < x_i + len_i·UNIT_W. Strict on both sides, so touching edges do not overlap.
- Landing on i: overlap AND prev_foot_y ≥ T_i AND foot_y ≤ T_i. len_i = 0 never hits.
- FSM has three states: IDLE, SCAN, DONE.
  - IDLE/DONE → SCAN on `scan_start`. On entry, latch player_x, foot_y, prev_foot_y, set idx = 0, and clear the partial best.
  - SCAN evaluates entry idx against the live descriptor inputs and the latched player values. idx increments each cycle.
  - SCAN → DONE after evaluating idx = N−1. In that cycle the result registers are updated from the final best.
  - DONE → IDLE unconditionally, unless `scan_start` is high.
- Best selection: the hit with the largest T_i wins. On equal T_i, the lower index wins.
- `block_switch` high while in SCAN: idx resets to 0 and the partial best clears. The scan restarts against the new descriptors.
- `block_switch` coincident with an accepted `scan_start` has no additional effect.
- `scan_start` while in SCAN is ignored.
- Result registers (`land_*`, `ceil_*`) hold from DONE until the next DONE. They are not cleared at scan start.

## Timing
- Reset values: `busy` = 0, `scan_done` = 0, `land_hit` = 0, `land_idx` = 0, `land_y` = 0, `ceil_hit` = 0, `ceil_y` = 0. FSM = IDLE.
- Reset asserted mid-scan aborts the scan and produces no `scan_done`.
- Latency: `scan_start` is high in cycle c. `busy` is high in cycles c+1 … c+N.
- `scan_done` and the new results appear in cycle c+N+1. For N = 7 that is 8 cycles.
- Each `block_switch` seen during SCAN adds the number of entries already evaluated to the latency.
- `scan_done` is high for exactly one cycle. `busy` and `scan_done` are never high together.
- A `scan_start` in the `scan_done` cycle is accepted, giving back-to-back scans every N+1 cycles.
- Descriptor inputs must be stable while `busy` is high, except across a `block_switch`.

## Configuration
- `PLAT_CEIL_HIT_EN` defined:
  - Head-bump detection runs in the same scan. Let H_prev = prev_foot_y + CHAR_W and H = foot_y + CHAR_W.
  - Bump on i: overlap AND H_prev ≤ y_i AND H ≥ y_i.
  - The lowest y_i wins; on a tie, the lower index wins. Results go to `ceil_hit` and `ceil_y`.
- `PLAT_CEIL_HIT_EN` undefined: the ceiling logic is not built, and `ceil_hit` and `ceil_y` are tied to 0.

## Test plan
- Basic landing. Platform 0 at x=280, y=75, len=10 (right edge 360, T=83); others len=0. player_x=300, prev_foot_y=90, foot_y=80, `scan_start` for 1 cycle → `busy` for 7 cycles, then `scan_done` with `land_hit`=1, `land_idx`=0, `land_y`=83.
- Edge exclusion. Same platform, player_x=264 (right edge 280 = x_0) → `land_hit`=0. player_x=359 → `land_hit`=1.
- Highest wins. Entries 3 and 5 overlap with T=120 and T=100; prev_foot_y=130, foot_y=90 → `land_idx`=3, `land_y`=120. With a tie at T=120 on entries 2 and 3 → `land_idx`=2.
- Restart. Pulse `block_switch` in the 4th `busy` cycle while swapping descriptors → `scan_done` arrives 3 cycles late and the result reflects only the new descriptors.
- Handshake and reset. `scan_start` held high continuously → `scan_done` every 8 cycles. `sys_rst` in the 3rd `busy` cycle → no `scan_done`, all outputs 0.
- Ceiling, with `PLAT_CEIL_HIT_EN` defined. Platform at y=200; prev_foot_y=170, foot_y=190 (H_prev=186, H=206) → `ceil_hit`=1, `ceil_y`=200. With the macro undefined → `ceil_hit`=0.
